// File: rtl/aes_pkg.sv
// Shared definitions for the AES load controller: the controller state
// encoding and the block and word widths used across the AES datapath.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int WORD_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COLLECT,
        COMMIT,
        START,
        WAIT,
        OUT
    } ctrl_state_t;

endpackage

// File: rtl/aes_load_ctrl.sv
// Sequencer in front of the 128-bit word collector and the AES round core.
// Collects WORDS stream words per group and tags the group as key or data
// from its first word. Key groups are committed to the key register. Data
// groups are committed to the block register and then launch the core, and
// the controller holds the result handshake until the consumer takes it.
// Optional build macro AES_LOAD_CTRL_TIMEOUT_EN adds a watchdog on core_done
// that abandons the operation and raises err_timeout after TIMEOUT_CYCLES
// cycles in WAIT; without it err_timeout is tied low.
module aes_load_ctrl #(
    parameter int WORD_W         = aes_pkg::WORD_W,
    parameter int WORDS          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_is_key,
    output logic              in_ready,
    output logic [WORD_W-1:0] col_data,
    output logic              col_enable,
    output logic              col_new_key,
    output logic              key_we,
    output logic              blk_we,
    output logic              core_start,
    input  logic              core_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              key_loaded,
    output logic              err_nokey,
    output logic              err_timeout
);
    import aes_pkg::*;

    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    // A group must exactly fill one AES block, and the watchdog needs a
    // positive limit.
    generate
        if (WORD_W * WORDS != AES_BLK_W) begin : g_bad_group_width
            $error("aes_load_ctrl: WORD_W*WORDS must equal AES_BLK_W");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("aes_load_ctrl: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    ctrl_state_t      state;
    logic [CNT_W-1:0] word_cnt;
    logic             group_is_key;
    logic             accept;

    assign accept     = in_valid & in_ready;
    assign col_data   = in_data;
    assign col_enable = accept;

`ifdef AES_LOAD_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] wdog_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    // Controller sequencing; every strobe is registered so that it is high
    // for exactly the cycle spent in the state it belongs to.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            word_cnt     <= '0;
            group_is_key <= 1'b0;
            in_ready     <= 1'b0;
            col_new_key  <= 1'b0;
            key_we       <= 1'b0;
            blk_we       <= 1'b0;
            core_start   <= 1'b0;
            out_valid    <= 1'b0;
            key_loaded   <= 1'b0;
            err_nokey    <= 1'b0;
`ifdef AES_LOAD_CTRL_TIMEOUT_EN
            err_timeout  <= 1'b0;
            wdog_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        col_new_key <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    col_new_key <= 1'b0;
                    in_ready    <= 1'b1;
                    state       <= COLLECT;
                end
                COLLECT: begin
                    if (accept) begin
                        if (word_cnt == '0) begin
                            group_is_key <= in_is_key;
                        end
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            in_ready <= 1'b0;
                            state    <= COMMIT;
                            if ((word_cnt == '0) ? in_is_key : group_is_key) begin
                                key_we <= 1'b1;
                            end else if (key_loaded) begin
                                blk_we <= 1'b1;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    key_we <= 1'b0;
                    blk_we <= 1'b0;
                    if (group_is_key) begin
                        key_loaded <= 1'b1;
                        state      <= IDLE;
                    end else if (key_loaded) begin
                        core_start <= 1'b1;
                        state      <= START;
                    end else begin
                        err_nokey <= 1'b1;
                        state     <= IDLE;
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    state      <= WAIT;
`ifdef AES_LOAD_CTRL_TIMEOUT_EN
                    wdog_cnt   <= '0;
`endif
                end
                WAIT: begin
                    if (core_done) begin
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
`ifdef AES_LOAD_CTRL_TIMEOUT_EN
                    else if (wdog_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_load_ctrl.md
Name: aes_load_ctrl

Overview:
- Sequencer in front of the 128-bit word collector and the AES round core.
- Accepts 32-bit words over a valid/ready stream, each 4-word group tagged as key or data.
- Drives the collector's enable and new_key, commits each completed group to the key register or the block register, then launches the core and holds the result handshake.
- Keeps its own word count; the collector's valid/counter outputs are not used for sequencing.

Parameters:
- WORD_W, 32, stream word width; must equal the collector input width.
- WORDS, 4, words per 128-bit group; WORD_W*WORDS = 128.
- TIMEOUT_CYCLES, 64, watchdog limit on core_done; used only with AES_LOAD_CTRL_TIMEOUT_EN.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  stream word valid.
- in_data  in  WORD_W  stream word; first word of a group is bits [127:96].
- in_is_key  in  1  group type; sampled on the first accepted word of a group only.
- in_ready  out  1  controller accepts a word this cycle.
- col_data  out  WORD_W  word to the collector; equals in_data.
- col_enable  out  1  collector shift strobe; equals in_valid & in_ready.
- col_new_key  out  1  collector clear strobe; one cycle per group.
- key_we  out  1  one-cycle strobe: latch collector output as key.
- blk_we  out  1  one-cycle strobe: latch collector output as plaintext block.
- core_start  out  1  one-cycle core launch.
- core_done  in  1  core finished; level or pulse, sampled only in WAIT.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- key_loaded  out  1  a key has been committed since reset.
- err_nokey  out  1  sticky: a data group arrived with no key loaded.
- err_timeout  out  1  sticky watchdog error; tied 0 without the macro.

Behaviour:
- Reset, async on RST_N low: state IDLE; word counter 0; all outputs 0; key_loaded 0; both error flags 0. Deassertion takes effect on the next CLK edge.
- States:
  - IDLE: in_ready=0. If in_valid, go to CLEAR.
  - CLEAR: col_new_key=1 for one cycle; in_ready=0; then COLLECT.
  - COLLECT: in_ready=1. On each accepted word the counter increments. The first accepted word latches type := in_is_key; later words ignore in_is_key. When the 4th word is accepted, the counter returns to 0 and the state goes to COMMIT.
  - COMMIT: the collector now holds the full group.
    - Key group: key_we=1, key_loaded<=1, back to IDLE.
    - Data group with key_loaded=1: blk_we=1, go to START.
    - Data group with key_loaded=0: err_nokey<=1, no strobe, back to IDLE.
  - START: core_start=1 for one cycle; then WAIT.
  - WAIT: on core_done=1 go to OUT.
  - OUT: out_valid=1 until out_ready=1 is sampled with out_valid=1; then IDLE. out_valid never drops without that handshake.
- Latency:
  - First word accepted 2 cycles after in_valid rises in IDLE (IDLE, CLEAR, then acceptance in COLLECT).
  - key_we/blk_we occur 1 cycle after the 4th word is accepted.
  - core_start occurs 1 cycle after blk_we.
  - out_valid asserts 1 cycle after core_done.
- in_valid may drop mid-group: the controller waits in COLLECT with the counter held.
- A new key group may arrive after any completed operation. key_loaded stays 1; the new key overwrites the old one.
- Error flags clear only on reset.
- Reset mid-group or mid-core: the partial group is discarded; the next group starts with CLEAR.

Optional Feature:
- Macro: AES_LOAD_CTRL_TIMEOUT_EN.
- With the macro: a counter runs in WAIT. If core_done is still absent after TIMEOUT_CYCLES cycles in WAIT, err_timeout<=1 and the state returns to IDLE with no out_valid. The counter clears on entering WAIT.
- Without the macro: err_timeout is constant 0, there is no counter, and WAIT waits indefinitely.

Decomposition:
- Shared package aes_pkg:
  - state encoding typedef (IDLE, CLEAR, COLLECT, COMMIT, START, WAIT, OUT);
  - AES_BLK_W=128 and WORD_W=32 constants.
- Single flat module; no sub-module. The watchdog counter is inline under the macro.

Test Plan:
- Key load: from reset, send 4 words 0x2b7e1516, 0x28aed2a6, 0xabf71588, 0x09cf4f3c with in_is_key=1 -> col_new_key is 1 cycle before the first word, key_we is 1 cycle after the 4th, key_loaded=1, core_start never asserts.
- Encrypt: after the key, send data 0x3243f6a8, 0x885a308d, 0x313198a2, 0xe0370734 -> blk_we, then core_start next cycle; core_done after 10 cycles -> out_valid next cycle, held for 3 cycles with out_ready=0, drops after out_ready=1.
- No key: from reset, send a data group -> err_nokey=1, no blk_we, no core_start, state returns to IDLE and accepts the next group.
- Gaps and tag: in_valid toggles 1,0,1,0 across a key group with in_is_key=0 on words 2-4 -> group treated as key; 4 col_enable pulses total; key_we fires.
- Reset: assert RST_N low after the 2nd data word -> all outputs 0 asynchronously, key_loaded=0. A new key group then loads normally, starting with CLEAR.
- Timeout (macro on, TIMEOUT_CYCLES=8): core_done held 0 -> err_timeout=1 after 8 WAIT cycles, return to IDLE, out_valid stays 0.
